// File: rtl/instr_word_loader.sv
// instr_word_loader: packs {op, rg1, rg2, mode} field sets into 16-bit
// instruction words and writes them sequentially into instruction memory
// as a counted job, keeping a running XOR checksum of the words written.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no job; waiting for start
// LOAD  | accepting field sets, one memory write per transfer
// FIN   | one-cycle completion; done pulses, last write may retire here
module instr_word_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rg1,
  input  logic [4:0]        rg2,
  input  logic [1:0]        mode,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] word_cnt,
  output logic [15:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [15:0]       word;
  logic              xfer;
  logic              accept_start;

  assign word         = {op, rg1, rg2, mode};
  // A transfer coinciding with abort is discarded entirely.
  assign xfer         = in_valid && in_ready && !abort;
  assign accept_start = (state == IDLE) && start;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; the transfer that reaches the job count ends LOAD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (count == '0) ? FIN : LOAD;
      end
      LOAD: begin
        if (abort)                                    state_nxt = IDLE;
        else if (xfer && ((word_cnt + ONE) == count_q)) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded directly from state.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: ;
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      FIN: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Job parameters, registered write port, word counter and checksum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q    <= '0;
      count_q   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      word_cnt  <= '0;
      checksum  <= '0;
    end else begin
      mem_we <= xfer;
      if (accept_start) begin
        base_q   <= base_addr;
        count_q  <= count;
        word_cnt <= '0;
        checksum <= '0;
      end
      if (xfer) begin
        // word_cnt doubles as the write index; the sum wraps at ADDR_W bits.
        mem_addr  <= base_q + word_cnt;
        mem_wdata <= word;
        word_cnt  <= word_cnt + ONE;
        checksum  <= checksum ^ word;
      end
    end
  end

endmodule

// File: tb/tb_instr_word_loader.sv
// Directed bench for instr_word_loader with hand-computed expectations.
module tb_instr_word_loader;
  logic        clk = 1'b0;
  logic        rst_n, start, abort, in_valid;
  logic [7:0]  base_addr, count;
  logic [3:0]  op;
  logic [4:0]  rg1, rg2;
  logic [1:0]  mode;
  logic        in_ready, mem_we, busy, done;
  logic [7:0]  mem_addr, word_cnt;
  logic [15:0] mem_wdata, checksum;

  int total = 0;
  int bad   = 0;

  instr_word_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rg1(rg1), .rg2(rg2), .mode(mode), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .word_cnt(word_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  // Field sets and their packed words (computed by hand).
  // w0: op=1 rg1=2  rg2=3  mode=0 -> 0x110C
  // w1: op=F rg1=31 rg2=31 mode=3 -> 0xFFFF
  // w2: op=5 rg1=16 rg2=1  mode=2 -> 0x5806
  // w3: op=0 rg1=1  rg2=0  mode=1 -> 0x0081
  logic [3:0]  f_op   [4] = '{4'h1, 4'hF, 4'h5, 4'h0};
  logic [4:0]  f_rg1  [4] = '{5'd2, 5'd31, 5'd16, 5'd1};
  logic [4:0]  f_rg2  [4] = '{5'd3, 5'd31, 5'd1, 5'd0};
  logic [1:0]  f_mode [4] = '{2'd0, 2'd3, 2'd2, 2'd1};
  logic [15:0] f_word [4] = '{16'h110C, 16'hFFFF, 16'h5806, 16'h0081};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int n);
    op   = f_op[n];
    rg1  = f_rg1[n];
    rg2  = f_rg2[n];
    mode = f_mode[n];
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".in_ready"},  in_ready,  0);
    chk({tag, ".mem_we"},    mem_we,    0);
    chk({tag, ".busy"},      busy,      0);
    chk({tag, ".done"},      done,      0);
    chk({tag, ".mem_addr"},  mem_addr,  0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".word_cnt"},  word_cnt,  0);
    chk({tag, ".checksum"},  checksum,  0);
  endtask

  logic v_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [7:0] wrap_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    int n;
    // Reset with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start = 1'($urandom); abort = 1'($urandom); in_valid = 1'($urandom);
      base_addr = 8'($urandom); count = 8'($urandom);
      op = 4'($urandom); rg1 = 5'($urandom); rg2 = 5'($urandom); mode = 2'($urandom);
      tick();
    end
    chk_all_zero("reset");

    start = 0; abort = 0; in_valid = 0;
    rst_n = 1'b1;
    tick();

    // Single word job.
    start = 1; base_addr = 8'h10; count = 8'd1;
    tick();
    start = 0;
    chk("single.in_ready", in_ready, 1);
    chk("single.busy", busy, 1);
    op = 4'hA; rg1 = 5'd3; rg2 = 5'd17; mode = 2'd1; in_valid = 1;
    tick();
    in_valid = 0;
    chk("single.mem_we",    mem_we,    1);
    chk("single.mem_addr",  mem_addr,  8'h10);
    chk("single.mem_wdata", mem_wdata, 16'hA1C5);
    chk("single.done",      done,      1);
    chk("single.checksum",  checksum,  16'hA1C5);
    chk("single.word_cnt",  word_cnt,  1);
    chk("single.in_ready_end", in_ready, 0);
    tick();
    chk("single.busy_end", busy, 0);
    chk("single.done_end", done, 0);
    chk("single.we_end",   mem_we, 0);
    chk("single.cnt_hold", word_cnt, 1);

    // Wrap-around with gaps in in_valid.
    start = 1; base_addr = 8'hFE; count = 8'd4;
    tick();
    start = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = v_pat[i];
      set_fields(n < 4 ? n : 3);
      tick();
      chk($sformatf("wrap.we%0d", i), mem_we, v_pat[i]);
      if (v_pat[i]) begin
        chk($sformatf("wrap.addr%0d", n), mem_addr, wrap_addr[n]);
        chk($sformatf("wrap.data%0d", n), mem_wdata, f_word[n]);
        n++;
      end
      chk($sformatf("wrap.done%0d", i), done, (i == 5) ? 1 : 0);
    end
    in_valid = 0;
    chk("wrap.checksum", checksum, 16'hB674);
    chk("wrap.word_cnt", word_cnt, 4);
    tick();
    chk("wrap.busy_end", busy, 0);
    chk("wrap.we_end", mem_we, 0);

    // Zero-count job.
    start = 1; base_addr = 8'h33; count = 8'd0; in_valid = 1;
    tick();
    start = 0;
    chk("zero.done",     done,     1);
    chk("zero.busy",     busy,     1);
    chk("zero.mem_we",   mem_we,   0);
    chk("zero.word_cnt", word_cnt, 0);
    chk("zero.checksum", checksum, 0);
    chk("zero.in_ready", in_ready, 0);
    tick();
    in_valid = 0;
    chk("zero.done_end", done, 0);
    chk("zero.busy_end", busy, 0);
    chk("zero.we_end", mem_we, 0);

    // Abort on the third valid word.
    start = 1; base_addr = 8'h40; count = 8'd5;
    tick();
    start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; set_fields(i);
      tick();
      chk($sformatf("abort.we%0d", i), mem_we, 1);
      chk($sformatf("abort.addr%0d", i), mem_addr, 8'h40 + 8'(i));
    end
    in_valid = 1; abort = 1; set_fields(2);
    tick();
    in_valid = 0; abort = 0;
    chk("abort.mem_we",   mem_we,   0);
    chk("abort.busy",     busy,     0);
    chk("abort.done",     done,     0);
    chk("abort.word_cnt", word_cnt, 2);
    chk("abort.checksum", checksum, 16'hEEF3);
    tick();
    chk("abort.done_after", done, 0);

    // Start ignored while busy, then reset mid-job.
    start = 1; base_addr = 8'h80; count = 8'd4;
    tick();
    start = 0;
    in_valid = 1; set_fields(0);
    tick();
    chk("midjob.addr0", mem_addr, 8'h80);
    start = 1; base_addr = 8'h20; count = 8'd1; set_fields(1);
    tick();
    start = 0;
    chk("midjob.we1",   mem_we,   1);
    chk("midjob.addr1", mem_addr, 8'h81);
    chk("midjob.cnt",   word_cnt, 2);
    chk("midjob.done",  done,     0);
    chk("midjob.busy",  busy,     1);
    rst_n = 0; set_fields(2);
    tick();
    chk_all_zero("midrst");
    rst_n = 1; set_fields(3);
    tick();
    chk_all_zero("postrst");
    in_valid = 0;
    tick();
    chk("postrst.we2", mem_we, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
